// File: rtl/display_pkg.sv
// display_pkg
//   Shared types and constants for the seven-segment display scanner.
//   state_e : scan state (idle/dark, blanking window, digit lit).
//   SEG_OFF : segment pattern with every segment dark.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_OFF = 8'h00;

endpackage : display_pkg

// File: rtl/seven_segment.sv
// seven_segment
//   Combinational hex to seven-segment encoder for common-cathode displays.
//   Ports:
//     code_i [4:0] : {dot, nibble}
//     seg_o  [7:0] : pgfedcba, 1 = segment lit
module seven_segment
  import display_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [7:0] seg_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_OFF[6:0];
    case (code_i[3:0])
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = SEG_OFF[6:0];
    endcase
  end

  assign seg_o = {code_i[4], glyph};

endmodule : seven_segment

// File: rtl/display_scanner.sv
// display_scanner
//   Time-multiplexes DIGITS hex digits onto one shared common-cathode
//   seven-segment bus, with a dark blanking window at the start of every
//   digit slot and a double-buffered display value.
//   Parameters:
//     DIGITS   : number of digits (1..8)
//     PRESCALE : clock cycles per digit slot (>= BLANK+1)
//     BLANK    : dark cycles at the start of each slot (0 = no blanking)
//   Ports:
//     clk_i       : system clock
//     rst_ni      : synchronous active-low reset
//     enable_i    : scan enable; low keeps the display idle and dark
//     load_i      : one-cycle strobe capturing value_i / dots_i
//     value_i     : nibble per digit, digit k = value_i[4k+3:4k]
//     dots_i      : decimal point per digit
//     pending_o   : a loaded value waits for the next frame boundary
//     segments_o  : pgfedcba of the digit being shown
//     digit_o     : one-hot digit strobe, 0 = all off
//     frame_o     : pulse on the last lit cycle of the last digit
module display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dots_i,
  output logic                  pending_o,
  output logic [7:0]            segments_o,
  output logic [DIGITS-1:0]     digit_o,
  output logic                  frame_o
);

  // The parameter BLANK shares its name with a state, so states are
  // referenced through the package scope in this module.
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  // Every slot starts dark unless blanking is disabled.
  localparam display_pkg::state_e SLOT_START =
    (BLANK > 0) ? display_pkg::BLANK : display_pkg::SHOW;

  display_pkg::state_e state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    idx_q;

  logic [4*DIGITS-1:0] active_val_q;
  logic [DIGITS-1:0]   active_dots_q;
  logic [4*DIGITS-1:0] shadow_val_q;
  logic [DIGITS-1:0]   shadow_dots_q;
  logic                pending_q;

  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   digit_q;
  logic                frame_q;

  // Digit mux feeding the single shared encoder.
  logic [4:0] code_tbl [DIGITS];
  logic [4:0] code_d;
  logic [7:0] enc_seg;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_code
    assign code_tbl[gi] = {active_dots_q[gi], active_val_q[4*gi +: 4]};
  end

  assign code_d = code_tbl[idx_q];

  seven_segment u_enc (
    .code_i (code_d),
    .seg_o  (enc_seg)
  );

  logic frame_end;
  logic commit;

  // frame_end marks the last SHOW cycle of the last digit. The active
  // buffer may only change at that boundary or when the scan drops to
  // idle, so a frame never mixes old and new digits.
  assign frame_end = (state_q == display_pkg::SHOW) && (cnt_q == CNT_LAST) &&
                     (idx_q == IDX_LAST);
  assign commit    = (state_q != display_pkg::IDLE) && (frame_end || !enable_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= display_pkg::IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      active_val_q  <= '0;
      active_dots_q <= '0;
      shadow_val_q  <= '0;
      shadow_dots_q <= '0;
      pending_q     <= 1'b0;
      seg_q         <= display_pkg::SEG_OFF;
      digit_q       <= '0;
      frame_q       <= 1'b0;
    end else begin
      // Scan state machine
      if (!enable_i) begin
        state_q <= display_pkg::IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
      end else begin
        case (state_q)
          display_pkg::IDLE: begin
            state_q <= SLOT_START;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
          display_pkg::BLANK: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == BLANK_LAST) begin
              state_q <= display_pkg::SHOW;
            end
          end
          display_pkg::SHOW: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
              state_q <= SLOT_START;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= display_pkg::IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        endcase
      end

      // Registered outputs follow the current state, one cycle behind it.
      if (state_q == display_pkg::SHOW) begin
        digit_q <= DIGITS'(1) << idx_q;
        seg_q   <= enc_seg;
      end else begin
        digit_q <= '0;
        seg_q   <= display_pkg::SEG_OFF;
      end
      frame_q <= frame_end;

      // Double buffer: a load lands in the active buffer directly while
      // idle or at a commit point, otherwise it parks in the shadow.
      if (state_q == display_pkg::IDLE) begin
        if (load_i) begin
          active_val_q  <= value_i;
          active_dots_q <= dots_i;
        end
        pending_q <= 1'b0;
      end else if (commit) begin
        if (load_i) begin
          active_val_q  <= value_i;
          active_dots_q <= dots_i;
        end else if (pending_q) begin
          active_val_q  <= shadow_val_q;
          active_dots_q <= shadow_dots_q;
        end
        pending_q <= 1'b0;
      end else if (load_i) begin
        shadow_val_q  <= value_i;
        shadow_dots_q <= dots_i;
        pending_q     <= 1'b1;
      end
    end
  end

  assign segments_o = seg_q;
  assign digit_o    = digit_q;
  assign frame_o    = frame_q;
  assign pending_o  = pending_q;

endmodule : display_scanner

// File: tb/tb_display_scanner.sv
// tb_display_scanner
//   Directed bench for display_scanner with DIGITS=4, PRESCALE=8, BLANK=2:
//   each digit slot is 2 dark cycles followed by 6 lit cycles.
module tb_display_scanner;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  logic        clk_i;
  logic        rst_ni;
  logic        enable_i;
  logic        load_i;
  logic [15:0] value_i;
  logic [3:0]  dots_i;
  logic        pending_o;
  logic [7:0]  segments_o;
  logic [3:0]  digit_o;
  logic        frame_o;

  int n_checks = 0;
  int n_pass   = 0;

  display_scanner #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .enable_i   (enable_i),
    .load_i     (load_i),
    .value_i    (value_i),
    .dots_i     (dots_i),
    .pending_o  (pending_o),
    .segments_o (segments_o),
    .digit_o    (digit_o),
    .frame_o    (frame_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load(input logic [15:0] lv, input logic [3:0] ld);
    value_i = lv;
    dots_i  = ld;
    load_i  = 1'b1;
    $display("load value=%h dots=%b pending_o=%0b", lv, ld, pending_o);
  endtask

  // One digit slot: two dark cycles, then lit_n lit cycles. If load_at
  // matches a lit cycle index, a load is presented for the following edge.
  task automatic slot(input int d, input logic [7:0] seg, input int lit_n,
                      input int load_at, input logic [15:0] lv, input logic [3:0] ld);
    logic [3:0] exp_dig;
    exp_dig = 4'b0001 << d;
    for (int i = 0; i < 2; i++) begin
      step();
      load_i = 1'b0;
      chk("dark_digit", {28'd0, digit_o}, 32'd0);
      chk("dark_seg", {24'd0, segments_o}, 32'd0);
    end
    for (int i = 0; i < lit_n; i++) begin
      step();
      load_i = 1'b0;
      chk($sformatf("lit_digit%0d", d), {28'd0, digit_o}, {28'd0, exp_dig});
      chk($sformatf("lit_seg%0d", d), {24'd0, segments_o}, {24'd0, seg});
      chk($sformatf("frame%0d_%0d", d, i), {31'd0, frame_o}, {31'd0, (d == 3 && i == 5)});
      if (i == load_at) do_load(lv, ld);
    end
  endtask

  task automatic frame4(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
    slot(0, s0, 6, -1, 16'h0, 4'h0);
    slot(1, s1, 6, -1, 16'h0, 4'h0);
    slot(2, s2, 6, -1, 16'h0, 4'h0);
    slot(3, s3, 6, -1, 16'h0, 4'h0);
    $display("frame done segs=%h %h %h %h", s0, s1, s2, s3);
  endtask

  initial begin
    rst_ni   = 1'b0;
    enable_i = 1'b1;
    load_i   = 1'b0;
    value_i  = '0;
    dots_i   = '0;

    // Reset dominates enable.
    step();
    step();
    chk("rst_seg", {24'd0, segments_o}, 32'd0);
    chk("rst_digit", {28'd0, digit_o}, 32'd0);
    chk("rst_frame", {31'd0, frame_o}, 32'd0);
    chk("rst_pending", {31'd0, pending_o}, 32'd0);

    // Load in IDLE goes straight to the active buffer.
    rst_ni = 1'b1;
    do_load(16'h1234, 4'b0000);
    step();
    load_i = 1'b0;
    chk("idle_lag_digit", {28'd0, digit_o}, 32'd0);
    chk("idle_load_pending", {31'd0, pending_o}, 32'd0);

    // Frame 1: 1234, load 0000 mid digit 1 goes to the shadow.
    slot(0, 8'h66, 6, -1, 16'h0, 4'h0);
    slot(1, 8'h4F, 6, 2, 16'h0000, 4'b0000);
    chk("pend_set", {31'd0, pending_o}, 32'd1);
    slot(2, 8'h5B, 6, -1, 16'h0, 4'h0);
    chk("pend_hold", {31'd0, pending_o}, 32'd1);
    slot(3, 8'h06, 6, -1, 16'h0, 4'h0);
    chk("pend_clr", {31'd0, pending_o}, 32'd0);

    // Frame 2: 0000, load 5555 on the boundary cycle.
    slot(0, 8'h3F, 6, -1, 16'h0, 4'h0);
    slot(1, 8'h3F, 6, -1, 16'h0, 4'h0);
    slot(2, 8'h3F, 6, -1, 16'h0, 4'h0);
    slot(3, 8'h3F, 6, 4, 16'h5555, 4'b0000);
    chk("pend_boundary", {31'd0, pending_o}, 32'd0);

    // Frame 3: 5555, load ABCD with dot on digit 2.
    slot(0, 8'h6D, 6, -1, 16'h0, 4'h0);
    slot(1, 8'h6D, 6, -1, 16'h0, 4'h0);
    slot(2, 8'h6D, 6, 2, 16'hABCD, 4'b0100);
    chk("pend_abcd", {31'd0, pending_o}, 32'd1);
    slot(3, 8'h6D, 6, -1, 16'h0, 4'h0);
    chk("pend_abcd_clr", {31'd0, pending_o}, 32'd0);

    // Frame 4: ABCD.
    frame4(8'h5E, 8'h39, 8'hFC, 8'h77);

    // Frame 5: drop enable during digit 2 SHOW.
    slot(0, 8'h5E, 6, -1, 16'h0, 4'h0);
    slot(1, 8'h39, 6, -1, 16'h0, 4'h0);
    slot(2, 8'hFC, 3, -1, 16'h0, 4'h0);
    enable_i = 1'b0;
    $display("enable_i dropped during digit 2");
    step();
    chk("dis_lag_digit", {28'd0, digit_o}, 32'h4);
    chk("dis_lag_seg", {24'd0, segments_o}, 32'hFC);
    step();
    chk("dis_dark_digit", {28'd0, digit_o}, 32'd0);
    chk("dis_dark_seg", {24'd0, segments_o}, 32'd0);
    step();
    step();
    chk("idle_digit", {28'd0, digit_o}, 32'd0);
    chk("idle_pending", {31'd0, pending_o}, 32'd0);

    // Re-enable restarts at digit 0.
    enable_i = 1'b1;
    step();
    chk("reen_lag_digit", {28'd0, digit_o}, 32'd0);
    slot(0, 8'h5E, 6, -1, 16'h0, 4'h0);
    slot(1, 8'h39, 6, 1, 16'h0000, 4'b0000);
    chk("pend_before_rst", {31'd0, pending_o}, 32'd1);

    // Reset while a load is pending.
    rst_ni = 1'b0;
    step();
    chk("rst2_seg", {24'd0, segments_o}, 32'd0);
    chk("rst2_digit", {28'd0, digit_o}, 32'd0);
    chk("rst2_frame", {31'd0, frame_o}, 32'd0);
    chk("rst2_pending", {31'd0, pending_o}, 32'd0);
    rst_ni = 1'b1;
    step();
    chk("rst2_lag_digit", {28'd0, digit_o}, 32'd0);
    frame4(8'h3F, 8'h3F, 8'h3F, 8'h3F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_display_scanner

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexes DIGITS hex digits onto one shared common-cathode seven-segment bus.
- Drives a single instance of the team's seven_segment encoder (5-bit {dot,nibble} in, pgfedcba out).
- Generates one-hot digit strobes with a per-slot blanking window to stop ghosting.
- Double-buffers the displayed value so a load never tears a frame.

Parameters:
DIGITS, 4, number of multiplexed digits; legal range 1..8.
PRESCALE, 1000, clock cycles per digit slot; must be >= BLANK+1.
BLANK, 16, cycles at the start of each slot with all strobes and segments off; 0 disables blanking.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  reset, synchronous, active-low.
enable_i  in  1  scan enable; low holds the block idle and dark.
load_i  in  1  single-cycle strobe; captures value_i/dots_i.
value_i  in  4*DIGITS  nibble per digit; digit k = value_i[4k+3:4k].
dots_i  in  DIGITS  decimal point per digit; bit k = digit k.
pending_o  out  1  a loaded value is waiting for the next frame boundary.
segments_o  out  8  pgfedcba; 1 = segment lit.
digit_o  out  DIGITS  one-hot digit strobe; 0 = all off.
frame_o  out  1  one-cycle pulse on the last lit cycle of digit DIGITS-1.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - state IDLE, slot counter 0, digit index 0.
  - active and shadow buffers 0, pending 0.
  - segments_o=0, digit_o=0, frame_o=0, pending_o=0.
  - Reset overrides all other inputs and discards any pending load.
- State machine, decided on the registered state and counter:
  - IDLE: enable_i=1 -> BLANK with counter 0, digit 0. Otherwise stay.
  - BLANK: counter < BLANK. Counter increments; on reaching BLANK -> SHOW. If BLANK=0, SHOW is entered directly from IDLE and at every slot start.
  - SHOW: counter increments. At counter = PRESCALE-1, the counter wraps to 0 and the digit index advances (DIGITS-1 wraps to 0). Next state is BLANK, or SHOW if BLANK=0.
  - Any state, enable_i=0 -> IDLE; counter and digit index reset to 0.
- Outputs are registered and lag the internal state by exactly one cycle. digit_o and segments_o update on the same edge and are never skewed.
  - In BLANK/IDLE: digit_o=0, segments_o=0.
  - In SHOW for digit k: digit_o = 1<<k, segments_o = encoder({dots[k], nibble[k]}) taken from the active buffer.
  - frame_o=1 on the output cycle matching the SHOW cycle where digit index = DIGITS-1 and counter = PRESCALE-1.
- Load handshake (always accepted, no back-pressure):
  - In IDLE: load_i writes value_i/dots_i straight to the active buffer. pending stays 0.
  - Otherwise: load_i writes the shadow buffer and sets pending. A later load before the boundary overwrites the shadow (last load wins).
  - Frame boundary is the cycle where digit DIGITS-1 wraps to 0. At the boundary, if pending: active <= shadow, pending <= 0.
  - load_i on the boundary cycle: active <= value_i directly, pending <= 0. The new value shows from digit 0 of the next frame.
  - pending_o is the registered pending flag.
- enable_i falling mid-slot: outputs go dark one cycle later. The buffers and pending are kept; a pending value is applied to active on entry to IDLE.
- Counter width is $clog2(PRESCALE); digit index width is $clog2(DIGITS), minimum 1. The counter and index never exceed their terminal values.

Decomposition:
- Package display_pkg holds:
  - state enum {IDLE, BLANK, SHOW};
  - SEG_OFF = 8'h00.
- Sub-module: one instance of the existing seven_segment encoder, fed by a DIGITS:1 mux of {dot, nibble}. There is no other sub-module.

Test Plan (DIGITS=4, PRESCALE=8, BLANK=2):
1. Reset, then enable_i=1 and load 0x1234, dots 0 while IDLE.
   -> 2 dark cycles, then digit_o=0001/segments 0x66 for 6 cycles.
   -> 2 dark cycles, then 0010/0x4F, then 0100/0x5B, then 1000/0x06.
   -> frame_o pulses on the last 1000 cycle.
2. Load value 0xABCD, dots 4'b0100.
   -> digit 2 shows 0xFC (b with dot); digit 0 shows 0x5E; digit 3 shows 0x77.
3. Load 0x0000 during the digit-1 slot of a frame displaying 0x1234.
   -> pending_o=1; digits 1..3 still show 0x4F/0x5B/0x06.
   -> next frame digit 0 shows 0x3F; pending_o clears after the boundary.
4. Load 0x5555 exactly on the boundary cycle.
   -> pending_o stays 0; the following digit 0 shows 0x6D.
5. enable_i=0 during the digit-2 SHOW.
   -> the next output cycle is digit_o=0, segments 0.
   -> re-enable restarts at digit 0 after 2 dark cycles.
6. rst_ni=0 for one cycle while pending_o=1.
   -> all outputs 0, pending_o=0.
   -> re-enable shows 0x3F on every digit.
